// File: rtl/serial_adder_arbiter.sv
// Bit-serial add/subtract engine sharing one full-adder cell between two
// requesters under round-robin arbitration; one result bit per clock, LSB first.
module serial_adder_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             sub0,
  input  logic             sub1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_id_q, done_id_d;
  logic             s, maj, sel, sub_sel;
  logic [WIDTH-1:0] b_sel;

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    sel       = 1'b0;
    sub_sel   = 1'b0;
    b_sel     = '0;
    s         = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    maj       = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    unique case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins; last_q=1 favours requester 0.
        gnt0 = req0 & (~req1 | last_q);
        gnt1 = req1 & ~gnt0;
        if (gnt0 || gnt1) begin
          sel      = gnt1;
          sub_sel  = sel ? sub1 : sub0;
          b_sel    = sel ? b1 : b0;
          a_sh_d   = sel ? a1 : a0;
          b_sh_d   = sub_sel ? ~b_sel : b_sel;
          carry_d  = sub_sel;
          cnt_d    = '0;
          owner_d  = sel;
          last_d   = sel;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = {s, res_sh_q[WIDTH-1:1]};
        carry_d  = maj;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB; maj is the carry out of it.
          result_d  = {s, res_sh_q[WIDTH-1:1]};
          cout_d    = maj;
          ovf_d     = carry_q ^ maj;
          done_id_d = owner_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Sequencer that shares one full-adder cell between two requesters, performing WIDTH-bit add/subtract bit-serially, LSB first. A round-robin arbiter accepts one operation at a time. The block captures the operands, runs one full-adder evaluation per clock, and returns sum, carry-out and signed overflow with a one-cycle done pulse. It sits between small control clients and the gate-level full-adder datapath, giving area-cheap arithmetic for multi-cycle-tolerant paths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; held until granted.
- sub0 / sub1  in  1  0 = a+b, 1 = a−b, for the respective requester.
- a0, b0 / a1, b1  in  WIDTH  operands; must be stable while req is high.
- gnt0 / gnt1  out  1  combinational grant; transfer occurs on the edge where reqN && gntN.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; result fields are valid.
- done_id  out  1  requester that owns the completed result.
- result  out  WIDTH  sum/difference.
- cout  out  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Grants are driven only in IDLE, and at most one gnt is high.
  - Round-robin arbitration:
    - Single request: that requester is granted.
    - Both requesting: grant the requester not served last.
    - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - On a transfer edge:
    - A_sh ← a; B_sh ← sub ? ~b : b.
    - carry ← sub; cnt ← 0.
    - owner ← id; the last-served pointer updates.
    - Next state is RUN.
- RUN, one bit per edge:
  - s = A_sh[0] ^ B_sh[0] ^ carry.
  - carry ← majority(A_sh[0], B_sh[0], carry).
  - A_sh and B_sh shift right.
  - The result shift register takes s in at the MSB.
  - Before the final bit (cnt == WIDTH−1), latch the carry into the MSB so ovf can be formed.
  - At cnt == WIDTH−1 the edge moves the block to DONE and loads result, cout, ovf, done_id.
- DONE:
  - done = 1 for exactly one cycle, then the next edge returns to IDLE.
- Output registers hold their values until the next completion.
- Requests arriving while busy are not granted and stay pending. They are arbitrated in the next IDLE cycle.
- Operands are sampled only at the transfer edge. Later changes on a/b/sub have no effect.

## Timing
- Transfer edge E0. Bit k is processed on edge E(k+1).
- done is high during the cycle after edge E(WIDTH), i.e. WIDTH cycles after the transfer edge.
- Back-to-back throughput: one operation per WIDTH+2 cycles (RUN ×WIDTH, DONE, IDLE/grant).
- Reset, asynchronous, any state:
  - State returns to IDLE; a run in progress is aborted with no done.
  - Outputs go to: busy=0, done=0, done_id=0, result=0, cout=0, ovf=0.
  - gnt0/gnt1 depend only on req in IDLE.
  - Pointer resets to favour requester 0.
- Reset release: the first rising edge with rst_n high can be a transfer edge.

## Test plan
- Add, WIDTH=8:
  - req0, a0=0x3C, b0=0x05, sub0=0 → gnt0 in the request cycle.
  - done 8 cycles after transfer, with result=0x41, cout=0, ovf=0, done_id=0.
- Signed overflow and wrap:
  - 0x7F+0x01 → result=0x80, ovf=1, cout=0.
  - 0xFF+0x01 → result=0x00, cout=1, ovf=0.
- Subtract on requester 1:
  - 0x05−0x07 → result=0xFE, cout=0, ovf=0, done_id=1.
  - 0x80−0x01 → result=0x7F, cout=1, ovf=1.
- Arbitration:
  - req0 and req1 asserted together from reset → requester 0 served first, then requester 1.
  - The next simultaneous pair is served 0 then 1 again (alternating).
  - gnt stays low while busy=1.
- Reset mid-run:
  - Assert rst_n=0 on the 4th RUN cycle → busy and result drop to 0 immediately, and done never pulses.
  - A request made after release completes normally.
- Operand stability:
  - Change a0/b0 on the cycle after transfer → the result reflects the captured values only.
